wb_stage: RTL

//  RV32I writeback stage: MEM/WB pipeline register, load-data alignment/extension and writeback mux.

---
 rtl/wb_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB pipeline register, load-data alignment and
// extension, writeback mux and a retired-instruction counter. The register
// file write port (reg_write/rd/write_data) is driven combinationally from
// the latched instruction, so the register file samples it one edge later.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_rdata,
    input  logic [31:0]      in_pc_plus4,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    output logic             reg_write,
    output logic [4:0]       rd,
    output logic [31:0]      write_data,
    output logic             wb_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retire_count
);

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [31:0] pc_plus4;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
    } latch_t;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    latch_t             latch_reg;
    latch_t             latch_next;
    logic               written_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [7:0]         rdata_bytes [4];
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_value;
    logic               load_misaligned;
    logic               first_cycle;
    logic               retire;

    // Fresh instruction from the MEM stage, captured when neither flushed nor stalled.
    always_comb begin
        latch_next            = latch_reg;
        latch_next.valid      = in_valid;
        latch_next.reg_write  = in_reg_write;
        latch_next.rd         = in_rd;
        latch_next.wb_sel     = in_wb_sel;
        latch_next.alu_result = in_alu_result;
        latch_next.mem_rdata  = in_mem_rdata;
        latch_next.pc_plus4   = in_pc_plus4;
        latch_next.funct3     = in_funct3;
        latch_next.addr_lo    = in_addr_lo;
    end

    // MEM/WB latch and written flag: reset > flush > stall > load.
    // A bubble zeroes every field so rd/write_data read 0 after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            latch_reg   <= '0;
            written_reg <= 1'b0;
        end else if (flush) begin
            latch_reg   <= '0;
            written_reg <= 1'b0;
        end else if (stall) begin
            written_reg <= written_reg | latch_reg.valid;
        end else begin
            latch_reg   <= latch_next;
            written_reg <= 1'b0;
        end
    end

    // Retire counter: one count per instruction on its first cycle unless misaligned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (retire) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Byte lanes of the loaded word, indexed by address bits [1:0].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rdata_bytes[gi] = latch_reg.mem_rdata[gi*8 +: 8];
    end

    // Load alignment/extension and misalignment detection.
    always_comb begin
        byte_sel = rdata_bytes[latch_reg.addr_lo];
        half_sel = latch_reg.addr_lo[1] ? latch_reg.mem_rdata[31:16]
                                        : latch_reg.mem_rdata[15:0];
        case (latch_reg.funct3)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {24'h0, byte_sel};
            3'b101:  load_value = {16'h0, half_sel};
            default: load_value = latch_reg.mem_rdata;
        endcase
        case (latch_reg.funct3)
            3'b000, 3'b100: load_misaligned = 1'b0;
            3'b001, 3'b101: load_misaligned = latch_reg.addr_lo[0];
            default:        load_misaligned = (latch_reg.addr_lo != 2'b00);
        endcase
    end

    // Writeback mux and write-port qualification; the write fires only on the
    // first cycle an instruction sits in the latch, even while stalled.
    always_comb begin
        case (latch_reg.wb_sel)
            SEL_ALU: write_data = latch_reg.alu_result;
            SEL_MEM: write_data = load_value;
            SEL_PC4: write_data = latch_reg.pc_plus4;
            default: write_data = 32'h0;
        endcase
        first_cycle  = latch_reg.valid & ~written_reg;
        misalign_err = first_cycle & (latch_reg.wb_sel == SEL_MEM) & load_misaligned;
        reg_write    = first_cycle & latch_reg.reg_write & (latch_reg.rd != 5'd0)
                     & ~misalign_err & (latch_reg.wb_sel != 2'b11);
        retire       = first_cycle & ~misalign_err;
    end

    assign rd           = latch_reg.rd;
    assign wb_valid     = latch_reg.valid;
    assign retire_count = count_reg;

endmodule
